// File: rtl/mt_bus_pkg.sv
// Shared types and constants for the Mersenne-Twister bus initiator.
// The FSM state encoding and the default register map of the PRNG slave.
package mt_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    READ,
    DONE,
    ERR
  } state_e;

  localparam logic [31:0] DEF_SEED_ADDR = 32'h0000_0004;
  localparam logic [31:0] DEF_RV_ADDR   = 32'h0000_0000;
  localparam logic [3:0]  STROBE_ALL    = 4'hF;

endpackage

// File: rtl/mt_rv_fifo.sv
// Result FIFO: DEPTH x DATA_W, registered occupancy, no fall-through.
// A pop on empty is ignored; a push on full is accepted only with a same-cycle pop.
module mt_rv_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers/count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mt_bus_initiator.sv
// Bus initiator for the MT PRNG slave: optional seed write, then a counted burst of
// reads streamed out through a small FIFO. All bus outputs are registered.
module mt_bus_initiator
  import mt_bus_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                CNT_W     = 16,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] SEED_ADDR = ADDR_W'(DEF_SEED_ADDR),
  parameter logic [ADDR_W-1:0] RV_ADDR   = ADDR_W'(DEF_RV_ADDR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                seed_en,
  input  logic [DATA_W-1:0]   seed,
  input  logic [CNT_W-1:0]    count,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                bus_wen,
  output logic                bus_ren,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_strobe,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_error
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  state_e            state, state_n;
  logic [CNT_W-1:0]  remaining, remaining_n;
  logic              wen_n, ren_n, err_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [OCC_W-1:0]  fifo_cnt, occ_after;
  logic              room_next;

  assign bus_strobe = {(DATA_W/8){1'b1}};
  assign busy       = (state != IDLE);
  assign out_valid  = !fifo_empty;
  assign fifo_pop   = out_valid && out_ready;
  assign fifo_push  = (state == READ) && bus_ren && !bus_error;

  // Occupancy after this edge decides whether the next cycle may carry a read,
  // so a registered ren can never push into a full FIFO.
  assign occ_after = fifo_cnt + OCC_W'(fifo_push) - OCC_W'(fifo_pop);
  assign room_next = (occ_after < OCC_W'(DEPTH));

  mt_rv_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bus_rdata),
    .pop       (fifo_pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    wen_n       = 1'b0;
    ren_n       = 1'b0;
    err_n       = err;
    addr_n      = bus_addr;
    wdata_n     = bus_wdata;
    case (state)
      IDLE: begin
        if (start) begin
          remaining_n = count;
          err_n       = 1'b0;
          if (seed_en) begin
            state_n = SEED;
            wen_n   = 1'b1;
            addr_n  = SEED_ADDR;
            wdata_n = seed;
          end else if (count != '0) begin
            state_n = READ;
            ren_n   = room_next;
            addr_n  = RV_ADDR;
          end else begin
            state_n = DONE;
          end
        end
      end
      SEED: begin
        if (bus_error) begin
          state_n = ERR;
          err_n   = 1'b1;
        end else if (remaining != '0) begin
          state_n = READ;
          ren_n   = room_next;
          addr_n  = RV_ADDR;
        end else begin
          state_n = DONE;
        end
      end
      READ: begin
        if (bus_ren && bus_error) begin
          state_n = ERR;
          err_n   = 1'b1;
        end else if (bus_ren) begin
          remaining_n = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state_n = DONE;
          else                        ren_n   = room_next;
        end else begin
          ren_n = room_next;
        end
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      bus_wen   <= 1'b0;
      bus_ren   <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      bus_wen   <= wen_n;
      bus_ren   <= ren_n;
      bus_addr  <= addr_n;
      bus_wdata <= wdata_n;
      err       <= err_n;
      done      <= (state == DONE) || (state == ERR);
    end
  end

endmodule

// File: tb/tb_mt_bus_initiator.sv
// Scoreboard bench for mt_bus_initiator: a combinational PRNG-slave stand-in answers
// bus accesses; expected results are queued at issue time and checked by a monitor.
module tb_mt_bus_initiator;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              seed_en = 1'b0;
  logic [DATA_W-1:0] seed = '0;
  logic [CNT_W-1:0]  count = '0;
  logic              busy, done, err, out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              bus_wen, bus_ren;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_strobe;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] resp[16];
  logic [31:0] exp_seed = '0;
  int          rd_idx = 0;
  logic        rd_clr = 1'b0;
  int          err_at = -1;
  int          wen_cnt = 0, ren_cnt = 0, done_cnt = 0;
  logic        prev_done = 1'b0;

  mt_bus_initiator #(.DEPTH(DEPTH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed_en    (seed_en),
    .seed       (seed),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .bus_wen    (bus_wen),
    .bus_ren    (bus_ren),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_strobe (bus_strobe),
    .bus_rdata  (bus_rdata),
    .bus_error  (bus_error)
  );

  always #5 clk = ~clk;

  // Slave stand-in: answers in the access cycle, advances only on a good read.
  assign bus_rdata = resp[rd_idx[3:0]];
  assign bus_error = bus_ren && (rd_idx == err_at);

  always @(posedge clk) begin
    if (rd_clr)                      rd_idx <= 0;
    else if (bus_ren && !bus_error)  rd_idx <= rd_idx + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: bus protocol, done pulse width, and scoreboard pops.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_wen || bus_ren) check("wen_ren_exclusive", 64'(bus_wen && bus_ren), 64'd0);
      if (bus_wen) begin
        wen_cnt++;
        check("wen_addr", 64'(bus_addr), 64'h4);
        check("wen_wdata", 64'(bus_wdata), 64'(exp_seed));
      end
      if (bus_ren) begin
        ren_cnt++;
        check("ren_addr", 64'(bus_addr), 64'h0);
      end
      if (done) begin
        done_cnt++;
        check("done_single_cycle", 64'(prev_done), 64'd0);
      end
      prev_done = done;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_data: got 0x%0h, expected no data at %0t", out_data, $time);
        end else begin
          check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
      end
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_resp();
    rd_clr = 1'b1;
    tick(1);
    rd_clr = 1'b0;
  endtask

  task automatic do_start(input logic se, input logic [31:0] sd, input logic [15:0] cnt);
    @(posedge clk);
    #1;
    start   = 1'b1;
    seed_en = se;
    seed    = sd;
    count   = cnt;
    tick(1);
    start   = 1'b0;
    seed_en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt > d0) break;
    end
    #1;
    if (done_cnt == d0) check({name, "_done_timeout"}, 64'(done_cnt - d0), 64'd1);
  endtask

  int w0, r0, d0;

  initial begin
    for (int i = 0; i < 16; i++) resp[i] = 32'hA000_0000 + 32'(i);

    // Reset values
    tick(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_wen_ren", 64'({bus_wen, bus_ren}), 64'd0);
    check("rst_addr", 64'(bus_addr), 64'd0);
    check("rst_wdata", 64'(bus_wdata), 64'd0);
    check("strobe", 64'(bus_strobe), 64'hF);
    rst = 1'b0;
    tick(2);

    // 1: seed 5489, three reads, MT19937 reference outputs
    resp[0] = 32'hD091_BB5C; resp[1] = 32'h22AE_9EF6; resp[2] = 32'hE7E1_FAEE;
    exp_seed = 32'd5489;
    clear_resp();
    exp_q.push_back(32'hD091_BB5C);
    exp_q.push_back(32'h22AE_9EF6);
    exp_q.push_back(32'hE7E1_FAEE);
    out_ready = 1'b1;
    w0 = wen_cnt; r0 = ren_cnt; d0 = done_cnt;
    do_start(1'b1, 32'd5489, 16'd3);
    check("t1_busy_after_start", 64'(busy), 64'd1);
    wait_done("t1", 40);
    tick(4);
    check("t1_wen_count", 64'(wen_cnt - w0), 64'd1);
    check("t1_ren_count", 64'(ren_cnt - r0), 64'd3);
    check("t1_done_count", 64'(done_cnt - d0), 64'd1);
    check("t1_err", 64'(err), 64'd0);
    check("t1_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 16; i++) resp[i] = 32'hA000_0000 + 32'(i);

    // 2: backpressure, count 8 into a 4-deep FIFO
    clear_resp();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hA000_0000 + 32'(i));
    out_ready = 1'b0;
    r0 = ren_cnt; d0 = done_cnt;
    do_start(1'b0, 32'd0, 16'd8);
    tick(10);
    check("t2_stall_ren_count", 64'(ren_cnt - r0), 64'd4);
    check("t2_stall_ren", 64'(bus_ren), 64'd0);
    check("t2_stall_busy", 64'(busy), 64'd1);
    check("t2_stall_out_valid", 64'(out_valid), 64'd1);
    check("t2_stall_no_done", 64'(done_cnt - d0), 64'd0);
    out_ready = 1'b1;
    wait_done("t2", 60);
    tick(6);
    check("t2_ren_count", 64'(ren_cnt - r0), 64'd8);
    check("t2_done_count", 64'(done_cnt - d0), 64'd1);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3: bus error on 2nd read of 5
    clear_resp();
    err_at = 1;
    exp_q.push_back(32'hA000_0000);
    r0 = ren_cnt; d0 = done_cnt;
    do_start(1'b0, 32'd0, 16'd5);
    wait_done("t3", 40);
    err_at = -1;
    check("t3_err_set", 64'(err), 64'd1);
    tick(5);
    check("t3_ren_count", 64'(ren_cnt - r0), 64'd2);
    check("t3_done_count", 64'(done_cnt - d0), 64'd1);
    check("t3_err_sticky", 64'(err), 64'd1);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // 4: count 0, no seed; the start also clears err
    w0 = wen_cnt; r0 = ren_cnt; d0 = done_cnt;
    do_start(1'b0, 32'd0, 16'd0);
    check("t4_err_cleared", 64'(err), 64'd0);
    check("t4_done_not_yet", 64'(done), 64'd0);
    tick(1);
    check("t4_done_2_cycles", 64'(done), 64'd1);
    check("t4_busy_dropped", 64'(busy), 64'd0);
    tick(3);
    check("t4_no_bus", 64'((wen_cnt - w0) + (ren_cnt - r0)), 64'd0);
    check("t4_done_count", 64'(done_cnt - d0), 64'd1);

    // 5: start held for 10 cycles during a 12-read command
    clear_resp();
    for (int i = 0; i < 12; i++) exp_q.push_back(32'hA000_0000 + 32'(i));
    r0 = ren_cnt; d0 = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b1;
    count = 16'd12;
    tick(10);
    start = 1'b0;
    wait_done("t5", 60);
    tick(6);
    check("t5_ren_count", 64'(ren_cnt - r0), 64'd12);
    check("t5_done_count", 64'(done_cnt - d0), 64'd1);
    check("t5_drained", 64'(exp_q.size()), 64'd0);

    // 6: seed with count 0
    exp_seed = 32'h1234_5678;
    w0 = wen_cnt; r0 = ren_cnt; d0 = done_cnt;
    do_start(1'b1, 32'h1234_5678, 16'd0);
    wait_done("t6", 20);
    tick(3);
    check("t6_wen_count", 64'(wen_cnt - w0), 64'd1);
    check("t6_ren_count", 64'(ren_cnt - r0), 64'd0);
    check("t6_done_count", 64'(done_cnt - d0), 64'd1);

    // 7: reset in the middle of READ
    clear_resp();
    out_ready = 1'b0;
    d0 = done_cnt;
    do_start(1'b0, 32'd0, 16'd8);
    tick(3);
    rst = 1'b1;
    #1;
    check("t7_rst_busy", 64'(busy), 64'd0);
    check("t7_rst_out_valid", 64'(out_valid), 64'd0);
    check("t7_rst_wen_ren", 64'({bus_wen, bus_ren}), 64'd0);
    check("t7_rst_addr", 64'(bus_addr), 64'd0);
    check("t7_rst_done_err", 64'({done, err}), 64'd0);
    tick(2);
    rst = 1'b0;
    out_ready = 1'b1;
    tick(6);
    check("t7_no_done", 64'(done_cnt - d0), 64'd0);
    check("t7_fifo_flushed", 64'(out_valid), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
